// File: rtl/control_unit_if.sv
// Control bundle between the controller and its environment: run/instruction
// in, datapath strobes and status out.
interface control_unit_if;
    logic       run;
    logic [7:0] instruction;
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic       pc_write;
    logic       imm_signed;
    logic       mem_to_reg;
    logic [2:0] alu_op;
    logic [2:0] state;
    logic       halted;
    logic       illegal_op;
    logic [7:0] instr_count;

    // Environment side: drives run/instruction, observes controls.
    modport master (
        output run, instruction,
        input  reg_write, mem_write, alu_src, pc_write, imm_signed, mem_to_reg,
        input  alu_op, state, halted, illegal_op, instr_count
    );

    // Controller side.
    modport slave (
        input  run, instruction,
        output reg_write, mem_write, alu_src, pc_write, imm_signed, mem_to_reg,
        output alu_op, state, halted, illegal_op, instr_count
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle Moore controller for the datapath: FETCH/DECODE/EXEC/WB with
// HALT, sticky illegal-opcode flag and a retired-instruction counter.
// Every output is a register, so controls never follow the live instruction.
module control_unit (
    input  logic                 clk,
    input  logic                 reset,
    control_unit_if.slave        bus
);
    typedef enum logic [2:0] {
        ST_FETCH  = 3'b000,
        ST_DECODE = 3'b001,
        ST_EXEC   = 3'b010,
        ST_WB     = 3'b011,
        ST_HALT   = 3'b100
    } state_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic       imm_signed;
        logic       mem_to_reg;
        logic [2:0] alu_op;
        logic       illegal;
    } ctrl_t;

    // Opcode -> control word.  HALT and NOP decode to all zeros; undefined
    // opcodes only raise the illegal bit and otherwise behave as NOP.
    function automatic ctrl_t decode(input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            4'h1: begin c.reg_write = 1'b1; c.alu_op = 3'b000; end
            4'h2: begin c.reg_write = 1'b1; c.alu_op = 3'b001; end
            4'h3: begin c.reg_write = 1'b1; c.alu_op = 3'b010; end
            4'h4: begin c.reg_write = 1'b1; c.alu_op = 3'b011; end
            4'h5: begin c.reg_write = 1'b1; c.alu_op = 3'b100; end
            4'h6: begin c.reg_write = 1'b1; c.alu_op = 3'b101; end
            4'h7: begin c.reg_write = 1'b1; c.alu_op = 3'b110; end
            4'h8: begin c.reg_write = 1'b1; c.alu_op = 3'b111; end
            4'h9: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.imm_signed = 1'b1; end
            4'hA: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = 3'b010; end
            4'hB: begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            4'hC: begin c.mem_write = 1'b1; c.alu_src = 1'b1; end
            4'hD, 4'hE: c.illegal = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t     state_q;
    logic [3:0] ir_op_q;      // opcode nibble of IR; operand nibble goes straight to the datapath
    logic       reg_write_q, mem_write_q, alu_src_q, pc_write_q, imm_signed_q, mem_to_reg_q;
    logic [2:0] alu_op_q;
    logic       halted_q, illegal_q;
    logic [7:0] count_q;

    logic [3:0] dec_op_d;
    ctrl_t      ctrl_d;

    // In DECODE the word being latched is decoded so EXEC controls appear with
    // IR; elsewhere only the stored IR is decoded.
    always_comb begin
        dec_op_d = (state_q == ST_DECODE) ? bus.instruction[7:4] : ir_op_q;
        ctrl_d   = decode(dec_op_d);
    end

    // Single sequencer: next state and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_FETCH;
            ir_op_q      <= 4'h0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            pc_write_q   <= 1'b0;
            imm_signed_q <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_op_q     <= 3'b000;
            halted_q     <= 1'b0;
            illegal_q    <= 1'b0;
            count_q      <= 8'd0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (bus.run) state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    ir_op_q <= bus.instruction[7:4];
                    if (bus.instruction[7:4] == 4'hF) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q      <= ST_EXEC;
                        alu_op_q     <= ctrl_d.alu_op;
                        alu_src_q    <= ctrl_d.alu_src;
                        imm_signed_q <= ctrl_d.imm_signed;
                        mem_to_reg_q <= ctrl_d.mem_to_reg;
                        mem_write_q  <= ctrl_d.mem_write;
                        if (ctrl_d.illegal) illegal_q <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    // Datapath controls held; strobes swap from mem to reg/pc.
                    state_q     <= ST_WB;
                    mem_write_q <= 1'b0;
                    reg_write_q <= ctrl_d.reg_write;
                    pc_write_q  <= 1'b1;
                end
                ST_WB: begin
                    state_q      <= ST_FETCH;
                    reg_write_q  <= 1'b0;
                    pc_write_q   <= 1'b0;
                    alu_src_q    <= 1'b0;
                    imm_signed_q <= 1'b0;
                    mem_to_reg_q <= 1'b0;
                    alu_op_q     <= 3'b000;
                    count_q      <= count_q + 8'd1;
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    assign bus.state       = state_q;
    assign bus.reg_write   = reg_write_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.alu_src     = alu_src_q;
    assign bus.pc_write    = pc_write_q;
    assign bus.imm_signed  = imm_signed_q;
    assign bus.mem_to_reg  = mem_to_reg_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.halted      = halted_q;
    assign bus.illegal_op  = illegal_q;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: expected per-cycle snapshots are queued as
// stimulus is applied and popped/compared after each active edge.
module tb_control_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    control_unit_if bus ();
    control_unit dut (.clk(clk), .reset(reset), .bus(bus));

    // Snapshot: {state, rw, mw, alu_src, pc_write, imm_signed, mem_to_reg, alu_op, halted, illegal, count}
    typedef logic [21:0] snap_t;
    snap_t exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;
    logic [7:0] exp_cnt;
    logic       exp_ill;

    function automatic snap_t observed();
        return {bus.state, bus.reg_write, bus.mem_write, bus.alu_src, bus.pc_write,
                bus.imm_signed, bus.mem_to_reg, bus.alu_op, bus.halted,
                bus.illegal_op, bus.instr_count};
    endfunction

    task automatic check(input string tag, input snap_t obs, input snap_t expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
        $display("txn %-22s state=%0d ctrl=%b halted=%b ill=%b cnt=%0d", tag,
                 obs[21:19], obs[18:10], obs[9], obs[8], obs[7:0]);
    endtask

    task automatic push(input string tag, input logic [2:0] st, input logic [8:0] c, input logic h);
        exp_q.push_back({st, c, h, exp_ill, exp_cnt});
        tag_q.push_back(tag);
    endtask

    task automatic tick();
        string t;
        snap_t e;
        @(posedge clk);
        #1;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        check(t, observed(), e);
    endtask

    // One instruction from FETCH with run high: DECODE, EXEC, WB, FETCH.
    task automatic run_instr(input string name, input logic [7:0] ins,
                             input logic [8:0] ex, input logic [8:0] wb,
                             input logic ill, input logic chg, input logic drop_run);
        bus.instruction = ins;
        bus.run = 1'b1;
        push({name, " DECODE"}, 3'd1, 9'd0, 1'b0); tick();
        if (drop_run) bus.run = 1'b0;
        if (ill) exp_ill = 1'b1;
        push({name, " EXEC"}, 3'd2, ex, 1'b0); tick();
        if (chg) bus.instruction = 8'h00;
        push({name, " WB"}, 3'd3, wb, 1'b0); tick();
        exp_cnt = exp_cnt + 8'd1;
        push({name, " FETCH"}, 3'd0, 9'd0, 1'b0); tick();
    endtask

    initial begin
        reset = 1'b0;
        bus.run = 1'b0;
        bus.instruction = 8'h00;
        exp_cnt = 8'd0;
        exp_ill = 1'b0;
        #12;
        check("reset", observed(), 22'd0);
        #5 reset = 1'b1;

        run_instr("ADD",  8'h16, 9'b0_0_0_0_0_0_000, 9'b1_0_0_1_0_0_000, 1'b0, 1'b0, 1'b0);
        run_instr("ST",   8'hC5, 9'b0_1_1_0_0_0_000, 9'b0_0_1_1_0_0_000, 1'b0, 1'b0, 1'b0);
        run_instr("ADDI", 8'h9E, 9'b0_0_1_0_1_0_000, 9'b1_0_1_1_1_0_000, 1'b0, 1'b1, 1'b0);
        run_instr("SHL",  8'h71, 9'b0_0_0_0_0_0_110, 9'b1_0_0_1_0_0_110, 1'b0, 1'b0, 1'b0);
        run_instr("ANDI", 8'hA4, 9'b0_0_1_0_0_0_010, 9'b1_0_1_1_0_0_010, 1'b0, 1'b0, 1'b0);
        run_instr("LD",   8'hB3, 9'b0_0_0_0_0_1_000, 9'b1_0_0_1_0_1_000, 1'b0, 1'b0, 1'b0);
        // run drops mid-instruction: instruction completes, then waits in FETCH
        run_instr("XOR",  8'h52, 9'b0_0_0_0_0_0_100, 9'b1_0_0_1_0_0_100, 1'b0, 1'b0, 1'b1);
        push("XOR idle", 3'd0, 9'd0, 1'b0); tick();
        run_instr("ILL",  8'hD0, 9'b0_0_0_0_0_0_000, 9'b0_0_0_1_0_0_000, 1'b1, 1'b0, 1'b0);
        run_instr("ADD2", 8'h16, 9'b0_0_0_0_0_0_000, 9'b1_0_0_1_0_0_000, 1'b0, 1'b0, 1'b0);

        // HALT: two cycles after FETCH, run ignored afterwards
        bus.instruction = 8'hF0;
        bus.run = 1'b1;
        push("HLT DECODE", 3'd1, 9'd0, 1'b0); tick();
        push("HLT enter", 3'd4, 9'd0, 1'b1); tick();
        for (int i = 0; i < 4; i++) begin
            bus.run = i[0];
            push("HLT hold", 3'd4, 9'd0, 1'b1); tick();
        end
        #2 reset = 1'b0;
        exp_cnt = 8'd0;
        exp_ill = 1'b0;
        #1 check("HLT async reset", observed(), 22'd0);
        bus.run = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        push("post reset idle", 3'd0, 9'd0, 1'b0); tick();

        // 256 NOPs wrap the retired counter back to 0
        for (int i = 0; i < 256; i++)
            run_instr("NOP", 8'h00, 9'd0, 9'b0_0_0_1_0_0_000, 1'b0, 1'b0, 1'b0);
        check("count wrap", {14'd0, bus.instr_count}, 22'd0);

        run_instr("LD2", 8'hB3, 9'b0_0_0_0_0_1_000, 9'b1_0_0_1_0_1_000, 1'b0, 1'b0, 1'b0);
        // reset in the middle of an LD's EXEC cycle
        bus.instruction = 8'hB3;
        push("LD3 DECODE", 3'd1, 9'd0, 1'b0); tick();
        push("LD3 EXEC", 3'd2, 9'b0_0_0_0_0_1_000, 1'b0); tick();
        #2 reset = 1'b0;
        exp_cnt = 8'd0;
        #1 check("LD mid-EXEC reset", observed(), 22'd0);
        @(negedge clk);
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
